dvp_capture_window: RTL

//  Parametrised DVP capture front end running in the camera pixel-clock domain.

---
 rtl/dvp_capture_pkg.sv | 32 +++
 rtl/dvp_capture_window_packer.sv | 50 +++++
 rtl/dvp_capture_window.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/dvp_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module : dvp_capture_pkg
// Brief  : Shared FSM type, decimation constants and sizing helpers for capture.
// Rev    : 1.0  initial release
// ============================================================================
package dvp_capture_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      CAP  = 2'd2,
      DONE = 2'd3
   } cap_state_t;

   localparam int DECIM_X1 = 1;
   localparam int DECIM_X2 = 2;
   localparam int DECIM_X4 = 4;

   // Width of the sensor column/row counters.
   localparam int CNT_W = 16;

   function automatic int img_pixels(input int w, input int h);
      return w * h;
   endfunction

   function automatic bit decim_legal(input int d);
      return (d == DECIM_X1) || (d == DECIM_X2) || (d == DECIM_X4);
   endfunction

endpackage
`default_nettype wire

// File: rtl/dvp_capture_window_packer.sv
`default_nettype none
// ============================================================================
// Module : dvp_byte_packer
// Brief  : Pairs DVP bytes (high byte first) into pixels and flags line edges.
// Rev    : 1.0  initial release
// ============================================================================
module dvp_byte_packer #(
   parameter int DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  href_i,
   input  logic [DATA_W-1:0]     data_i,
   output logic                  line_start_o,
   output logic                  line_end_o,
   output logic                  pix_valid_o,
   output logic [2*DATA_W-1:0]   pix_data_o
);

   logic              href_q;
   logic              phase_q;
   logic [DATA_W-1:0] hi_q;
   logic              phase_eff;

   assign line_start_o = href_i & ~href_q;
   assign line_end_o   = ~href_i & href_q;

   // A new line always restarts on the high byte, discarding any odd leftover.
   assign phase_eff   = line_start_o ? 1'b0 : phase_q;
   assign pix_valid_o = href_i & phase_eff;
   assign pix_data_o  = {hi_q, data_i};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         href_q  <= 1'b0;
         phase_q <= 1'b0;
         hi_q    <= '0;
      end else begin
         href_q <= href_i;
         if (href_i) begin
            if (!phase_eff) begin
               hi_q <= data_i;
            end
            phase_q <= ~phase_eff;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/dvp_capture_window.sv
`default_nettype none
// ============================================================================
// Module : dvp_capture_window
// Brief  : DVP capture front end: RGB565 packing, window crop, 1/2/4 decimation
//          and linear frame-cache writes. DVP_DOUBLE_BUFFER_EN adds A/B banks.
// Rev    : 1.0  initial release
// ============================================================================
module dvp_capture_window
   import dvp_capture_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int PIX_W  = 16,
   parameter int IMG_W  = 200,
   parameter int IMG_H  = 164,
   parameter int X_OFF  = 0,
   parameter int Y_OFF  = 0,
   parameter int DECIM  = 1,
   parameter int ADDR_W = 16,
   parameter bit VS_POL = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cap_en,
   input  logic              dvp_vsync,
   input  logic              dvp_href,
   input  logic [DATA_W-1:0] dvp_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [PIX_W-1:0]  wr_data,
   output logic              frame_done,
   output logic              frame_err,
   output logic              busy
`ifdef DVP_DOUBLE_BUFFER_EN
   ,
   output logic              wr_bank,
   output logic              rd_bank
`endif
);

   localparam int NPIX  = img_pixels(IMG_W, IMG_H);
   localparam int X_END = X_OFF + IMG_W * DECIM;
   localparam int Y_END = Y_OFF + IMG_H * DECIM;
   localparam logic [CNT_W-1:0]  DMASK    = CNT_W'(DECIM - 1);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NPIX - 1);
`ifdef DVP_DOUBLE_BUFFER_EN
   localparam longint NBANK = 2;
`else
   localparam longint NBANK = 1;
`endif

   generate
      if (!decim_legal(DECIM) || (PIX_W != 2 * DATA_W) ||
          (longint'(NPIX) * NBANK > (longint'(1) << ADDR_W))) begin : g_param_check
         $error("dvp_capture_window: illegal DECIM, PIX_W or ADDR_W");
      end
   endgenerate

   cap_state_t          state_q;
   logic                vs_q;
   logic                vs_start_q;
   logic [CNT_W-1:0]    col_q;
   logic [CNT_W-1:0]    row_q;
   logic [ADDR_W-1:0]   pix_cnt_q;
   logic [ADDR_W-1:0]   base;

   logic                vs_act;
   logic                line_start;
   logic                line_end;
   logic                pix_valid;
   logic [2*DATA_W-1:0] pix_data;
   logic [CNT_W-1:0]    col_rel;
   logic [CNT_W-1:0]    row_rel;
   logic                col_ok;
   logic                row_ok;
   logic                keep;
   logic                last_px;

   dvp_byte_packer #(
      .DATA_W (DATA_W)
   ) u_packer (
      .clk          (clk),
      .rst          (rst),
      .href_i       (dvp_href),
      .data_i       (dvp_data),
      .line_start_o (line_start),
      .line_end_o   (line_end),
      .pix_valid_o  (pix_valid),
      .pix_data_o   (pix_data)
   );

   assign vs_act = (dvp_vsync == VS_POL);

   // DECIM is a power of two, so the phase test is a low-bit mask.
   assign col_rel = col_q - CNT_W'(X_OFF);
   assign row_rel = row_q - CNT_W'(Y_OFF);
   assign col_ok  = (int'(col_q) >= X_OFF) && (int'(col_q) < X_END) && ((col_rel & DMASK) == '0);
   assign row_ok  = (int'(row_q) >= Y_OFF) && (int'(row_q) < Y_END) && ((row_rel & DMASK) == '0);
   assign keep    = col_ok & row_ok;
   assign last_px = (pix_cnt_q == LAST_IDX);

`ifdef DVP_DOUBLE_BUFFER_EN
   logic bank_q;
   assign base    = bank_q ? ADDR_W'(NPIX) : '0;
   assign wr_bank = bank_q;
   assign rd_bank = ~bank_q;
`else
   assign base = '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         vs_q       <= 1'b0;
         vs_start_q <= 1'b0;
         col_q      <= '0;
         row_q      <= '0;
         pix_cnt_q  <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         busy       <= 1'b0;
`ifdef DVP_DOUBLE_BUFFER_EN
         bank_q     <= 1'b0;
`endif
      end else begin
         vs_q       <= vs_act;
         vs_start_q <= vs_act & ~vs_q;
         wr_en      <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;

         if (vs_start_q) begin
            row_q <= '0;
         end else if (line_end) begin
            row_q <= row_q + CNT_W'(1);
         end

         if (line_start) begin
            col_q <= '0;
         end else if (pix_valid) begin
            col_q <= col_q + CNT_W'(1);
         end

         case (state_q)
            IDLE: begin
               if (vs_start_q && cap_en) begin
                  state_q   <= WAIT;
                  busy      <= 1'b1;
                  pix_cnt_q <= '0;
               end
            end
            WAIT: begin
               if (!vs_act) begin
                  state_q <= CAP;
               end
            end
            CAP: begin
               if (pix_valid && keep) begin
                  wr_en     <= 1'b1;
                  wr_addr   <= base + pix_cnt_q;
                  wr_data   <= PIX_W'(pix_data);
                  pix_cnt_q <= pix_cnt_q + ADDR_W'(1);
                  if (last_px) begin
                     state_q <= DONE;
                  end
               end else if (vs_start_q) begin
                  // Early vsync: abandon the frame, leave what was written in place.
                  state_q   <= IDLE;
                  frame_err <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            DONE: begin
               frame_done <= 1'b1;
`ifdef DVP_DOUBLE_BUFFER_EN
               bank_q     <= ~bank_q;
`endif
               if (vs_start_q && cap_en) begin
                  state_q   <= WAIT;
                  pix_cnt_q <= '0;
               end else begin
                  state_q <= IDLE;
                  busy    <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
